pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline; drives enable and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Resolves three conditions:
  - load-use hazards
  - taken branches resolved in EX
  - variable-latency data-memory accesses (req/ack) with a timeout
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MEM_TIMEOUT, 16, max wait cycles for mem_ack before the error state; legal range 1..255.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead_EX  in  1  instruction in EX is a load.
- WriteReg_EX  in  5  destination register of EX instruction.
- Rs_ID  in  5  source register rs of ID instruction.
- Rt_ID  in  5  source register rt of ID instruction.
- UsesRt_ID  in  1  ID instruction reads rt.
- BranchTaken_EX  in  1  branch/jump in EX is taken.
- MemReq_MEM  in  1  MEM instruction accesses dmem (MemRead|MemWrite).
- mem_ack  in  1  dmem access complete this cycle (may coincide with request).
- pc_en  out  1  PC load enable.
- en_IF_ID  out  1  IF_ID load enable.
- flush_IF_ID  out  1  IF_ID clear to NOP.
- en_ID_EX  out  1  ID_EX load enable.
- flush_ID_EX  out  1  ID_EX clear (bubble).
- en_EX_MEM  out  1  EX_MEM load enable.
- flush_MEM_WB  out  1  MEM_WB loads bubble (RegWrite/MemToReg = 0).
- mem_error  out  1  sticky timeout flag.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- FSM states:
  - RUN (reset)
  - MEM_WAIT
  - MEM_ERR
- wait_cnt: 8-bit counter.
- Async reset (reset=0) sets:
  - state=RUN, wait_cnt=0, stall_count=0, mem_error=0.
  - All enables and flushes per RUN with no hazard: pc_en=en_IF_ID=en_ID_EX=en_EX_MEM=1, all flushes=0.
- Hazard terms (combinational):
  - lu = MemRead_EX & WriteReg_EX!=0 & (WriteReg_EX==Rs_ID | (UsesRt_ID & WriteReg_EX==Rt_ID)).
  - mw = MemReq_MEM & !mem_ack.
- RUN:
  - mw=1: freeze.
    - pc_en, en_IF_ID, en_ID_EX, en_EX_MEM = 0.
    - flush_MEM_WB=1; IF_ID and ID_EX flushes = 0.
    - Next state MEM_WAIT, wait_cnt=1.
  - Else BranchTaken_EX=1: all enables 1, flush_IF_ID=1, flush_ID_EX=1. lu is ignored (wrong-path instruction).
  - Else lu=1: pc_en=0, en_IF_ID=0, flush_ID_EX=1, en_EX_MEM=1 (exactly one bubble).
  - Else: normal advance.
- MEM_WAIT:
  - Same freeze outputs as mw in RUN, held until mem_ack=1.
  - On mem_ack=1: outputs in that cycle are the RUN equations (mw=0), and the load completes into MEM_WB. Next state RUN, wait_cnt=0.
  - Else if wait_cnt==MEM_TIMEOUT: next state MEM_ERR, mem_error=1.
  - Else wait_cnt+1.
- MEM_ERR:
  - Absorbing until reset.
  - All enables 0, flush_MEM_WB=1, mem_error=1.
- Zero-wait access (MemReq_MEM & mem_ack in the same cycle): no stall, no state change.
- stall_count increments each cycle in which pc_en=0. A branch-only flush does not count. Saturates at all-ones.
- The flush/enable pair on one register: flush takes priority in the register. The controller never asserts flush with enable=0 except flush_MEM_WB during freeze.
- Reset asserted mid-wait: immediate return to RUN, counters cleared.

Decomposition:
- Shared package pipeline_pkg:
  - FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, MEM_ERR=2'd2).
  - Register-index width constant REG_W=5.
- Sub-module hazard_detect (combinational lu term), reusable by the forwarding unit.
- FSM and counters stay in the top.

Test Plan:
- Load-use: MemRead_EX=1, WriteReg_EX=8, Rs_ID=8 -> one cycle pc_en=0, en_IF_ID=0, flush_ID_EX=1; next cycle normal; stall_count=1.
- WriteReg_EX=0 with Rs_ID=0 load -> no stall.
- UsesRt_ID=0 with Rt match only -> no stall.
- Branch+load-use same cycle: BranchTaken_EX=1 and lu=1 -> flush_IF_ID=1, flush_ID_EX=1, pc_en=1, stall_count unchanged.
- Memory wait: MemReq_MEM=1, mem_ack low 3 cycles then high -> 3 cycles freeze with flush_MEM_WB=1; 4th cycle all enables 1, flush_MEM_WB=0, state RUN; stall_count=3.
- Timeout with MEM_TIMEOUT=4 and mem_ack never asserted -> mem_error=1 after cycle 5, all enables stay 0; reset low -> mem_error=0, pc_en=1.
- Reset during MEM_WAIT (2nd wait cycle) -> asynchronously state RUN, outputs at reset values before next clk edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline control blocks.
// Holds the hazard sequencer state encoding and the register-index width.
package pipeline_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_ERR  = 2'd2
   } ctrlState_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: an ID instruction reads the destination of a load in EX.
// Kept separate so the forwarding unit can share the same comparison.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic             MemRead_EX,
   input  logic [REG_W-1:0] WriteReg_EX,
   input  logic [REG_W-1:0] Rs_ID,
   input  logic [REG_W-1:0] Rt_ID,
   input  logic             UsesRt_ID,
   output logic             loadUse
);

   logic rsMatch;
   logic rtMatch;

   // Register zero is hard-wired, so a load targeting it never creates a dependency.
   assign rsMatch = (WriteReg_EX == Rs_ID);
   assign rtMatch = UsesRt_ID && (WriteReg_EX == Rt_ID);
   assign loadUse = MemRead_EX && (WriteReg_EX != '0) && (rsMatch || rtMatch);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, branch flushes and data-memory
// wait freezes with a timeout, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             MemRead_EX,
   input  logic [REG_W-1:0] WriteReg_EX,
   input  logic [REG_W-1:0] Rs_ID,
   input  logic [REG_W-1:0] Rt_ID,
   input  logic             UsesRt_ID,
   input  logic             BranchTaken_EX,
   input  logic             MemReq_MEM,
   input  logic             mem_ack,
   output logic             pc_en,
   output logic             en_IF_ID,
   output logic             flush_IF_ID,
   output logic             en_ID_EX,
   output logic             flush_ID_EX,
   output logic             en_EX_MEM,
   output logic             flush_MEM_WB,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [7:0]       TIMEOUT_CNT = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   ctrlState_t state;
   logic [7:0] waitCnt;
   logic       loadUse;
   logic       memWait;
   logic       freeze;

   hazard_detect uHazardDetect (
      .MemRead_EX  (MemRead_EX),
      .WriteReg_EX (WriteReg_EX),
      .Rs_ID       (Rs_ID),
      .Rt_ID       (Rt_ID),
      .UsesRt_ID   (UsesRt_ID),
      .loadUse     (loadUse)
   );

   assign memWait = MemReq_MEM && !mem_ack;

   // Output equations. While reset is held the outputs show the idle RUN
   // pattern regardless of inputs. A freeze (memory wait or error) beats a
   // branch flush, which beats a load-use bubble, since a taken branch kills
   // the dependent wrong-path instruction anyway.
   always_comb begin
      freeze       = 1'b0;
      pc_en        = 1'b1;
      en_IF_ID     = 1'b1;
      flush_IF_ID  = 1'b0;
      en_ID_EX     = 1'b1;
      flush_ID_EX  = 1'b0;
      en_EX_MEM    = 1'b1;
      flush_MEM_WB = 1'b0;
      if (reset) begin
         case (state)
            RUN:      freeze = memWait;
            MEM_WAIT: freeze = !mem_ack;
            MEM_ERR:  freeze = 1'b1;
            default:  freeze = 1'b0;
         endcase
         if (freeze) begin
            pc_en        = 1'b0;
            en_IF_ID     = 1'b0;
            en_ID_EX     = 1'b0;
            en_EX_MEM    = 1'b0;
            flush_MEM_WB = 1'b1;
         end else if (BranchTaken_EX) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
         end else if (loadUse) begin
            pc_en       = 1'b0;
            en_IF_ID    = 1'b0;
            flush_ID_EX = 1'b1;
         end
      end
   end

   // Memory-wait sequencer. waitCnt counts frozen cycles of the current access;
   // an access still unacknowledged after MEM_TIMEOUT waits is declared dead and
   // the pipeline parks in MEM_ERR until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         waitCnt   <= '0;
         mem_error <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (memWait) begin
                  state   <= MEM_WAIT;
                  waitCnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (mem_ack) begin
                  state   <= RUN;
                  waitCnt <= '0;
               end else if (waitCnt == TIMEOUT_CNT) begin
                  state     <= MEM_ERR;
                  mem_error <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            MEM_ERR: begin
               mem_error <= 1'b1;
            end
            default: begin
               state   <= RUN;
               waitCnt <= '0;
            end
         endcase
      end
   end

   // Any cycle the PC is held counts as a stall; branch flushes keep the PC moving.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (!pc_en && (stall_count != CNT_MAX)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;
   import pipeline_pkg::*;

   localparam int TIMEOUT = 4;
   localparam int CW      = 8;
   localparam int SAT     = (1 << CW) - 1;

   localparam logic [6:0] OUT_IDLE   = 7'b1101010;
   localparam logic [6:0] OUT_LU     = 7'b0001110;
   localparam logic [6:0] OUT_BRANCH = 7'b1111110;
   localparam logic [6:0] OUT_FREEZE = 7'b0000001;

   logic          clk = 1'b0;
   logic          reset;
   logic          MemRead_EX, UsesRt_ID, BranchTaken_EX, MemReq_MEM, mem_ack;
   logic [4:0]    WriteReg_EX, Rs_ID, Rt_ID;
   logic          pc_en, en_IF_ID, flush_IF_ID, en_ID_EX, flush_ID_EX, en_EX_MEM, flush_MEM_WB;
   logic          mem_error;
   logic [CW-1:0] stall_count;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .MemRead_EX     (MemRead_EX),
      .WriteReg_EX    (WriteReg_EX),
      .Rs_ID          (Rs_ID),
      .Rt_ID          (Rt_ID),
      .UsesRt_ID      (UsesRt_ID),
      .BranchTaken_EX (BranchTaken_EX),
      .MemReq_MEM     (MemReq_MEM),
      .mem_ack        (mem_ack),
      .pc_en          (pc_en),
      .en_IF_ID       (en_IF_ID),
      .flush_IF_ID    (flush_IF_ID),
      .en_ID_EX       (en_ID_EX),
      .flush_ID_EX    (flush_ID_EX),
      .en_EX_MEM      (en_EX_MEM),
      .flush_MEM_WB   (flush_MEM_WB),
      .mem_error      (mem_error),
      .stall_count    (stall_count)
   );

   typedef struct {
      logic       memRead;
      logic [4:0] writeReg;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       usesRt;
      logic       branch;
      logic       memReq;
      logic       ack;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [6:0] expOut;
      string      name;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: is an access outstanding, how many frozen cycles it
   // has cost, whether the pipeline died, and the stall total.
   bit mWaiting;
   bit mErr;
   int mFreezeLen;
   int mStall;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t mkStim(input bit memRead, input int wr, input int rs, input int rt,
                                    input bit usesRt, input bit branch, input bit memReq, input bit ack);
      stim_t s;
      s.memRead  = memRead;
      s.writeReg = 5'(wr);
      s.rs       = 5'(rs);
      s.rt       = 5'(rt);
      s.usesRt   = usesRt;
      s.branch   = branch;
      s.memReq   = memReq;
      s.ack      = ack;
      return s;
   endfunction

   function automatic logic [6:0] dutOut();
      return {pc_en, en_IF_ID, flush_IF_ID, en_ID_EX, flush_ID_EX, en_EX_MEM, flush_MEM_WB};
   endfunction

   function automatic bit modelFrozen(input stim_t s);
      if (mErr) return 1'b1;
      if (mWaiting) return !s.ack;
      return s.memReq && !s.ack;
   endfunction

   function automatic logic [6:0] modelOut(input stim_t s);
      bit lu;
      lu = s.memRead && (s.writeReg != 0) &&
           ((s.writeReg == s.rs) || (s.usesRt && (s.writeReg == s.rt)));
      if (modelFrozen(s)) return OUT_FREEZE;
      if (s.branch) return OUT_BRANCH;
      if (lu) return OUT_LU;
      return OUT_IDLE;
   endfunction

   task automatic modelStep(input stim_t s, input logic [6:0] o);
      bit frozen;
      frozen = modelFrozen(s);
      if (!o[6] && mStall < SAT) mStall++;
      if (mErr) return;
      if (frozen) begin
         mWaiting = 1'b1;
         mFreezeLen++;
         if (mFreezeLen > TIMEOUT) mErr = 1'b1;
      end else begin
         mWaiting   = 1'b0;
         mFreezeLen = 0;
      end
   endtask

   task automatic driveInputs(input stim_t s);
      MemRead_EX     = s.memRead;
      WriteReg_EX    = s.writeReg;
      Rs_ID          = s.rs;
      Rt_ID          = s.rt;
      UsesRt_ID      = s.usesRt;
      BranchTaken_EX = s.branch;
      MemReq_MEM     = s.memReq;
      mem_ack        = s.ack;
   endtask

   // One clock cycle: drive at negedge, check outputs mid-cycle, advance the
   // model at posedge and check the registered outputs just after.
   task automatic applyStimulus(input stim_t s, input string name, output logic [6:0] seen);
      logic [6:0] exp;
      @(negedge clk);
      driveInputs(s);
      #1;
      exp  = modelOut(s);
      seen = dutOut();
      checkOutput({name, "_outputs"}, 32'(seen), 32'(exp));
      @(posedge clk);
      modelStep(s, exp);
      #1;
      checkOutput({name, "_stall_count"}, 32'(stall_count), 32'(mStall));
      checkOutput({name, "_mem_error"}, 32'(mem_error), 32'(mErr));
   endtask

   task automatic doReset();
      @(negedge clk);
      driveInputs(mkStim(0, 0, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;
      #1;
      checkOutput("reset_outputs", 32'(dutOut()), 32'(OUT_IDLE));
      checkOutput("reset_stall_count", 32'(stall_count), 0);
      checkOutput("reset_mem_error", 32'(mem_error), 0);
      mWaiting = 1'b0; mErr = 1'b0; mFreezeLen = 0; mStall = 0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   vec_t       tbl[11];
   logic [6:0] seen;
   stim_t      idle, luStim, reqStim;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0;
      idle    = mkStim(0, 0, 0, 0, 0, 0, 0, 0);
      luStim  = mkStim(1, 8, 8, 0, 0, 0, 0, 0);
      reqStim = mkStim(0, 0, 0, 0, 0, 0, 1, 0);
      driveInputs(idle);

      tbl[0]  = '{mkStim(0, 0, 0, 0, 0, 0, 0, 0), OUT_IDLE,   "idle"};
      tbl[1]  = '{mkStim(1, 8, 8, 0, 0, 0, 0, 0), OUT_LU,     "lu_rs"};
      tbl[2]  = '{mkStim(1, 0, 0, 0, 1, 0, 0, 0), OUT_IDLE,   "lu_r0"};
      tbl[3]  = '{mkStim(1, 5, 3, 5, 0, 0, 0, 0), OUT_IDLE,   "rt_unused"};
      tbl[4]  = '{mkStim(1, 5, 3, 5, 1, 0, 0, 0), OUT_LU,     "lu_rt"};
      tbl[5]  = '{mkStim(1, 7, 7, 7, 1, 1, 0, 0), OUT_BRANCH, "branch_lu"};
      tbl[6]  = '{mkStim(0, 2, 1, 3, 1, 1, 0, 0), OUT_BRANCH, "branch"};
      tbl[7]  = '{mkStim(0, 0, 0, 0, 0, 0, 1, 1), OUT_IDLE,   "zero_wait"};
      tbl[8]  = '{mkStim(0, 9, 9, 9, 1, 0, 0, 0), OUT_IDLE,   "no_load"};
      tbl[9]  = '{mkStim(1, 4, 4, 0, 0, 0, 1, 1), OUT_LU,     "zero_wait_lu"};
      tbl[10] = '{mkStim(0, 0, 0, 0, 0, 1, 1, 1), OUT_BRANCH, "zero_wait_br"};

      doReset();
      $display("[TB] vector table");
      foreach (tbl[i]) begin
         applyStimulus(tbl[i].s, tbl[i].name, seen);
         checkOutput({tbl[i].name, "_table"}, 32'(seen), 32'(tbl[i].expOut));
      end
      checkOutput("table_stall_total", 32'(stall_count), 3);

      $display("[TB] load-use single bubble");
      doReset();
      applyStimulus(luStim, "lu_bubble", seen);
      applyStimulus(idle, "lu_after", seen);
      checkOutput("lu_after_idle", 32'(seen), 32'(OUT_IDLE));
      checkOutput("lu_stall_one", 32'(stall_count), 1);

      $display("[TB] memory wait of three cycles");
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(reqStim, "memwait_freeze", seen);
         checkOutput("memwait_frozen", 32'(seen), 32'(OUT_FREEZE));
      end
      applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 1), "memwait_ack", seen);
      checkOutput("memwait_ack_out", 32'(seen), 32'(OUT_IDLE));
      checkOutput("memwait_stall_three", 32'(stall_count), 3);
      applyStimulus(idle, "memwait_resume", seen);
      checkOutput("memwait_resume_out", 32'(seen), 32'(OUT_IDLE));

      $display("[TB] timeout and stall saturation");
      doReset();
      for (int i = 0; i < 5; i++) begin
         checkOutput("timeout_not_yet", 32'(mem_error), 0);
         applyStimulus(reqStim, "timeout_wait", seen);
      end
      checkOutput("timeout_error", 32'(mem_error), 1);
      for (int i = 0; i < 260; i++) applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1), "err_hold", seen);
      checkOutput("err_frozen", 32'(seen), 32'(OUT_FREEZE));
      checkOutput("stall_saturated", 32'(stall_count), SAT);
      doReset();
      checkOutput("err_cleared_pc_en", 32'(pc_en), 1);

      $display("[TB] reset during memory wait");
      doReset();
      applyStimulus(reqStim, "rst_wait1", seen);
      applyStimulus(reqStim, "rst_wait2", seen);
      @(negedge clk);
      driveInputs(reqStim);
      #1;
      checkOutput("rst_pre_frozen", 32'(dutOut()), 32'(OUT_FREEZE));
      reset = 1'b0;
      #1;
      checkOutput("rst_async_outputs", 32'(dutOut()), 32'(OUT_IDLE));
      checkOutput("rst_async_stall", 32'(stall_count), 0);
      checkOutput("rst_async_error", 32'(mem_error), 0);
      mWaiting = 1'b0; mErr = 1'b0; mFreezeLen = 0; mStall = 0;
      @(negedge clk);
      driveInputs(idle);
      reset = 1'b1;
      applyStimulus(idle, "rst_back_run", seen);
      checkOutput("rst_back_run_out", 32'(seen), 32'(OUT_IDLE));

      $display("[TB] randomized traffic");
      doReset();
      for (int i = 0; i < 600; i++) begin
         stim_t r;
         if (i % 150 == 149) doReset();
         r = mkStim($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) == 0), $urandom_range(0, 1));
         applyStimulus(r, "random", seen);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
